// File: rtl/alu_arb_pkg.sv
// Shared opcodes and FSM state encoding for the two-requester ALU arbiter.
// Used by alu4_core and alu_arb_ctrl.
package alu_arb_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

endpackage

// File: rtl/alu_arb_ctrl_if.sv
// Request/response bundle between the two requesters, the consumer and alu_arb_ctrl.
// gnt_cnt0/gnt_cnt1 carry live counts only when ALU_ARB_CNT_EN is defined.
interface alu_arb_ctrl_if #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [1:0]        req0_op;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [1:0]        req1_op;

    logic              resp_valid;
    logic              resp_ready;
    logic              resp_id;
    logic [DATA_W-1:0] resp_res;
    logic              resp_cout;

    logic [CNT_W-1:0]  gnt_cnt0;
    logic [CNT_W-1:0]  gnt_cnt1;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_res, resp_cout,
        input  gnt_cnt0, gnt_cnt1
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_res, resp_cout,
        output gnt_cnt0, gnt_cnt1
    );

endinterface

// File: rtl/alu4_core.sv
// Combinational 4-bit ALU: ADD/SUB with carry/borrow, AND/OR with cout=0.
// Result depends only on a, b and op.
module alu4_core (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [1:0] op,
    output logic [3:0] res,
    output logic       cout
);
    import alu_arb_pkg::*;

    logic [4:0] wide;

    always_comb begin
        wide = 5'd0;
        unique case (op)
            OP_ADD: wide = {1'b0, a} + {1'b0, b};
            // 5-bit wrap leaves bit 4 set exactly when a < b
            OP_SUB: wide = {1'b0, a} - {1'b0, b};
            OP_AND: wide = {1'b0, a & b};
            OP_OR:  wide = {1'b0, a | b};
            default: wide = 5'd0;
        endcase
    end

    assign res  = wide[3:0];
    assign cout = wide[4];

endmodule

// File: rtl/alu_arb_ctrl.sv
// Round-robin arbiter + IDLE/EXEC/RESP sequencer sharing one alu4_core.
// Define ALU_ARB_CNT_EN to build saturating per-requester grant counters.
module alu_arb_ctrl #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arb_ctrl_if.slave bus
);
    import alu_arb_pkg::*;

    state_t            state;
    logic              rr_ptr;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [1:0]        op_q;
    logic              id_q;

    logic              sel_id;
    logic              take;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [1:0]        sel_op;
    logic [3:0]        alu_res;
    logic              alu_cout;

    // rr_ptr only matters on a tie; a sole requester always wins
    assign sel_id = (bus.req0_valid && bus.req1_valid) ? rr_ptr
                                                      : bus.req1_valid;
    assign take   = (state == S_IDLE)
                 && (bus.req0_valid || bus.req1_valid);

    assign bus.req0_ready = take && !sel_id;
    assign bus.req1_ready = take &&  sel_id;

    assign sel_a  = sel_id ? bus.req1_a  : bus.req0_a;
    assign sel_b  = sel_id ? bus.req1_b  : bus.req0_b;
    assign sel_op = sel_id ? bus.req1_op : bus.req0_op;

    alu4_core u_core (
        .a    (a_q),
        .b    (b_q),
        .op   (op_q),
        .res  (alu_res),
        .cout (alu_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            rr_ptr         <= 1'b0;
            a_q            <= '0;
            b_q            <= '0;
            op_q           <= OP_ADD;
            id_q           <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_res   <= '0;
            bus.resp_cout  <= 1'b0;
            bus.resp_id    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (take) begin
                        a_q    <= sel_a;
                        b_q    <= sel_b;
                        op_q   <= sel_op;
                        id_q   <= sel_id;
                        rr_ptr <= ~sel_id;
                        state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    bus.resp_res   <= alu_res;
                    bus.resp_cout  <= alu_cout;
                    bus.resp_id    <= id_q;
                    bus.resp_valid <= 1'b1;
                    state          <= S_RESP;
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        state          <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_CNT_EN
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (bus.req0_valid && bus.req0_ready && cnt0 != '1)
                cnt0 <= cnt0 + CNT_W'(1);
            if (bus.req1_valid && bus.req1_ready && cnt1 != '1)
                cnt1 <= cnt1 + CNT_W'(1);
        end
    end

    assign bus.gnt_cnt0 = cnt0;
    assign bus.gnt_cnt1 = cnt1;
`else
    assign bus.gnt_cnt0 = {CNT_W{1'b0}};
    assign bus.gnt_cnt1 = {CNT_W{1'b0}};
`endif

endmodule
